// File: rtl/md_unit_if.sv
// Request/response bundle between the decode/execute stage and the multiply/divide unit.
// The initiator drives start/op/a/b; the unit answers with busy and the HI/LO registers.
interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit with architectural HI/LO registers.
// The result is computed when the request is accepted and committed after the busy window.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   hi_q, lo_q, temp_hi, temp_lo;
    logic          temp_valid;
    logic          load, commit, do_mthi, do_mtlo;

    logic [63:0]        result;
    logic               result_valid;
    logic signed [63:0] ext_a, ext_b;
    logic        [63:0] prod_u;
    logic signed [63:0] prod_s;
    logic signed [31:0] div_a, div_b, quo_s, rem_s;
    logic        [31:0] divu_b, quo_u, rem_u;
    logic               div_ovf;

    assign ext_a  = {{32{bus.a[31]}}, bus.a};
    assign ext_b  = {{32{bus.b[31]}}, bus.b};
    assign prod_s = ext_a * ext_b;
    assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

    // A divisor of 1 for the overflow case yields exactly the wrapped quotient and a zero remainder.
    assign div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    assign div_a   = bus.a;
    assign div_b   = (bus.b == 32'd0 || div_ovf) ? 32'sd1 : bus.b;
    assign quo_s   = div_a / div_b;
    assign rem_s   = div_a % div_b;
    assign divu_b  = (bus.b == 32'd0) ? 32'd1 : bus.b;
    assign quo_u   = bus.a / divu_b;
    assign rem_u   = bus.a % divu_b;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        result       = '0;
        result_valid = 1'b1;
        case (bus.op)
            3'd0:    result = prod_s;
            3'd1:    result = prod_u;
            3'd2:    begin
                result       = {rem_s, quo_s};
                result_valid = (bus.b != 32'd0);
            end
            3'd3:    begin
                result       = {rem_u, quo_u};
                result_valid = (bus.b != 32'd0);
            end
            default: result_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        load      = 1'b0;
        commit    = 1'b0;
        do_mthi   = 1'b0;
        do_mtlo   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0, 3'd1: begin
                            load      = 1'b1;
                            count_nxt = CW'(MULT_CYCLES);
                            state_nxt = RUN;
                        end
                        3'd2, 3'd3: begin
                            load      = 1'b1;
                            count_nxt = CW'(DIV_CYCLES);
                            state_nxt = RUN;
                        end
                        3'd4:    do_mthi = 1'b1;
                        3'd5:    do_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving here are dropped; the stall logic never issues them.
                count_nxt = count - CW'(1);
                if (count == CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the temp registers are reset too, so an aborted result can never leak out later.
            state      <= IDLE;
            count      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            temp_hi    <= '0;
            temp_lo    <= '0;
            temp_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (load) begin
                temp_hi    <= result[63:32];
                temp_lo    <= result[31:0];
                temp_valid <= result_valid;
            end
            if (commit && temp_valid) begin
                hi_q <= temp_hi;
                lo_q <= temp_lo;
            end
            if (do_mthi) hi_q <= bus.a;
            if (do_mtlo) lo_q <= bus.a;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a cycle-level reference model checked every cycle,
// plus directed operations with hand-computed HI/LO and busy-length expectations.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles and the result to install when they run out.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;
    bit          m_res_ok = 0;
    bit          model_live = 0;

    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return 64'(ua * ub);
            3'd2: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_left     = 0;
            m_hi       = '0;
            m_lo       = '0;
            m_res_ok   = 0;
            model_live = 1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_res_ok) begin
                m_hi = m_res_hi;
                m_lo = m_res_lo;
            end
        end else if (bus.start) begin
            if (bus.op <= 3'd3) begin
                m_left   = (bus.op <= 3'd1) ? MC : DC;
                m_res_ok = (bus.op <= 3'd1) || (bus.b != 32'd0);
                if (m_res_ok) {m_res_hi, m_res_lo} = model_result(bus.op, bus.a, bus.b);
            end else if (bus.op == 3'd4) begin
                m_hi = bus.a;
            end else if (bus.op == 3'd5) begin
                m_lo = bus.a;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("cycle_busy", 64'(bus.busy), 64'(m_left > 0));
            check("cycle_hi", 64'(bus.hi), 64'(m_hi));
            check("cycle_lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts busy cycles after the request, bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b);
        wait_idle(n);
        check({name, "_busy_len"}, 64'(n), 64'(exp_busy));
        check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);

        run_op("mult",  3'd0, 32'hFFFF_FFFF, 32'h0000_0002, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, MC, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'h0000_0002, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'd3, 32'h0000_0007, 32'h0000_0002, DC, 32'h0000_0001, 32'h0000_0003);
        run_op("div_negb", 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, DC, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0000_0000, 32'h8000_0000);
        run_op("mult_big", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, MC, 32'hC000_0000, 32'h8000_0000);

        // MTHI then MTLO on consecutive cycles, each visible the cycle after its request.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        bus.op = 3'd5; bus.a = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        check("mtlo_busy", 64'(bus.busy), 64'd0);

        // Reserved opcode leaves everything untouched.
        run_op("reserved", 3'd6, 32'hDEAD_BEEF, 32'h1, 0, 32'h1234_5678, 32'h9ABC_DEF0);

        // Division by zero keeps the preloaded HI/LO.
        run_op("pre_hi", 3'd4, 32'hAAAA_0000, 32'h0, 0, 32'hAAAA_0000, 32'h9ABC_DEF0);
        run_op("pre_lo", 3'd5, 32'h0000_BBBB, 32'h0, 0, 32'hAAAA_0000, 32'h0000_BBBB);
        run_op("divu0",  3'd3, 32'h0000_0005, 32'h0, DC, 32'hAAAA_0000, 32'h0000_BBBB);
        run_op("div0",   3'd2, 32'hFFFF_FFF0, 32'h0, DC, 32'hAAAA_0000, 32'h0000_BBBB);

        // DIV request on busy cycle 2 of a MULT is ignored.
        issue(3'd0, 32'h0000_0006, 32'h0000_0007);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(n);
        check("ignored_busy_len", 64'(n + 2), 64'(MC));
        check("ignored_hi", 64'(bus.hi), 64'd0);
        check("ignored_lo", 64'(bus.lo), 64'd42);
        repeat (DC + 2) @(negedge clk);
        check("ignored_no_late_lo", 64'(bus.lo), 64'd42);

        // Reset on busy cycle 4 of a DIV aborts it for good.
        issue(3'd3, 32'd50, 32'd7);
        repeat (3) @(negedge clk);
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        repeat (DC + 2) @(negedge clk);
        check("abort_no_commit_hi", 64'(bus.hi), 64'd0);
        check("abort_no_commit_lo", 64'(bus.lo), 64'd0);
        run_op("post_multu", 3'd1, 32'd3, 32'd4, MC, 32'd0, 32'd12);

        // Back-to-back: new request in the first idle cycle after completion.
        issue(3'd1, 32'h0001_0000, 32'h0001_0000);
        wait_idle(n);
        check("b2b_first_hi", 64'(bus.hi), 64'd1);
        run_op("b2b_second", 3'd3, 32'd100, 32'd9, DC, 32'd1, 32'd11);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide responder for the pipelined MIPS datapath: the decode/execute stage acts as initiator, issuing a one-cycle `start` with an operation code and two operands. The block answers with `busy` for a fixed latency, then commits the 64-bit result into its HI/LO registers. HI/LO are always readable, for mfhi/mflo. The stall unit consumes `busy` together with `start` to freeze younger mult/div/mf/mt instructions.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (≥1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request strobe
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op)
- a  in  32  operand rs
- b  in  32  operand rt
- busy  out  1  operation in flight
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset: busy=0, hi=0, lo=0, counter=0, pending result discarded. Applies at any point, including mid-operation.
- States: IDLE, RUN.
- IDLE + start + op∈{0..3}:
  - Compute the result from `a`/`b` as sampled at that edge; latch it into internal temp registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- IDLE + start + op=4: hi←a, same edge, busy stays 0. op=5: lo←a likewise.
- IDLE + start + op∈{6,7}: ignored.
- RUN:
  - busy=1. Counter decrements each edge.
  - On the edge where the counter reaches its last cycle: hi/lo←temp, busy→0, go to IDLE.
  - hi/lo hold their old values throughout RUN.
- start while in RUN: ignored entirely (no restart, no MTHI/MTLO). The initiator must not issue it; the stall logic guarantees this.
- Arithmetic:
  - MULT: signed 32×32→64; hi = bits[63:32], lo = bits[31:0]. MULTU: unsigned.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. DIVU: unsigned.
  - Division by zero (b=0): the operation still runs the full DIV_CYCLES of busy, but hi/lo are left unchanged at commit.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- busy is a registered output. Not combinational from start.

## Timing
- start sampled at edge E0 → busy=1 during cycles E0+1 … E0+N (N = MULT_CYCLES or DIV_CYCLES).
- busy=0 and new hi/lo visible from cycle E0+N+1.
- MTHI/MTLO sampled at E0 → value visible in cycle E0+1, with zero busy cycles.
- Back-to-back: a new start is accepted in the first cycle busy=0 after completion. The result of the previous operation is already visible in that cycle.
- Reset asserted in any RUN cycle → next cycle busy=0, hi=lo=0, and nothing commits afterward.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 → busy high exactly 5 cycles → hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy exactly 10 cycles → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo update the cycle after each start; busy never asserts.
- Preload hi=0xAAAA0000 and lo=0x0000BBBB via MTHI/MTLO, then DIVU a=5, b=0 → busy for 10 cycles → hi/lo still 0xAAAA0000/0x0000BBBB.
- Start MULT, pulse start with DIV on busy cycle 2 → the DIV is ignored; the MULT commits on schedule; busy drops after 5 cycles.
- Start DIV, assert reset on busy cycle 4 → next cycle busy=0, hi=lo=0; no commit ever occurs. A following MULTU 3×4 → lo=12, hi=0.
